// File: rtl/t2mi_ts_packer_mux.sv
// T2-MI to TS packer: wraps buffered T2-MI bytes into 188-byte TS packets per stream
// (PID + continuity counter), pads short payloads with AF stuffing, inserts nulls when idle.
module t2mi_ts_packer_mux #(
  parameter int          NUM_STREAMS = 4,
  parameter int          SEL_W       = 2,
  parameter int          GAP_W       = 16,
  parameter logic [12:0] NULL_PID    = 13'h1FFF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [SEL_W-1:0]         i_stream_sel,
  input  logic [7:0]               i_pointer,
  input  logic [7:0]               i_avail,
  input  logic [NUM_STREAMS*13-1:0] i_pid_table,
  input  logic                     i_null_en,
  input  logic [GAP_W-1:0]         i_null_gap,
  input  logic [7:0]               i_data_in,
  input  logic                     i_ena_in,
  output logic                     o_ready,
  output logic                     o_rd_req,
  output logic [7:0]               o_data_out,
  output logic                     o_ena_out,
  output logic                     o_psync_out,
  output logic                     o_err,
  output logic [3:0]               o_state_mon
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_HEADER    = 4'd1,
    S_AF_LEN    = 4'd2,
    S_AF_FLAGS  = 4'd3,
    S_AF_STUFF  = 4'd4,
    S_PTR       = 4'd5,
    S_PAYLOAD   = 4'd6,
    S_NULL_BODY = 4'd7
  } state_t;

  state_t            r_state, w_state_next;
  logic [7:0]        r_idx, w_idx_next;
  logic [SEL_W-1:0]  r_sel;
  logic [7:0]        r_ptr, r_p, r_f;
  logic              r_pusi, r_ptr_bad, r_null;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_next;
  logic [3:0]        r_cc [NUM_STREAMS];
  logic [7:0]        r_data, w_data_next;
  logic              r_ena, w_ena_next;
  logic              r_psync, w_psync_next;
  logic              r_err, w_err_next;
  logic              r_rd_req, w_rd_req_next;
  logic              w_accept, w_null_go, w_cc_inc;

  // Request decode, evaluated on the raw inputs and latched on accept.
  logic              w_sel_ok, w_pusi, w_clamp, w_ptr_bad, w_req_err;
  logic [SEL_W-1:0]  w_sel;
  logic [7:0]        w_cap, w_p, w_f;

  always_comb begin
    w_sel_ok = (int'(i_stream_sel) < NUM_STREAMS);
    w_sel    = w_sel_ok ? i_stream_sel : '0;
    w_pusi   = (i_pointer < 8'd184);
    w_cap    = w_pusi ? 8'd183 : 8'd184;
    w_p      = i_avail;
    w_clamp  = 1'b0;
    if (i_avail == 8'd0) begin
      w_p     = 8'd1;
      w_clamp = 1'b1;
    end else if (i_avail > w_cap) begin
      w_p     = w_cap;
      w_clamp = 1'b1;
    end
    w_f       = w_cap - w_p;
    w_ptr_bad = w_pusi && (i_pointer >= w_p);
    w_req_err = !w_sel_ok || w_clamp || w_ptr_bad;
  end

  logic [12:0] w_pid;
  logic [3:0]  w_cc_cur;
  logic [7:0]  w_ctrl;
  state_t      w_after_af;

  assign w_pid      = i_pid_table[int'(r_sel)*13 +: 13];
  assign w_cc_cur   = r_cc[r_sel];
  assign w_ctrl     = {2'b00, (r_f != 8'd0) ? 2'b11 : 2'b01, w_cc_cur};
  assign w_after_af = r_pusi ? S_PTR : S_PAYLOAD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_gap_next    = r_gap_cnt;
    w_data_next   = r_data;
    w_ena_next    = 1'b0;
    w_psync_next  = 1'b0;
    w_err_next    = 1'b0;
    w_rd_req_next = r_rd_req;
    w_accept      = 1'b0;
    w_null_go     = 1'b0;
    w_cc_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_err_next   = w_req_err;
          w_gap_next   = '0;
          w_state_next = S_HEADER;
        end else if (i_null_en) begin
          if (r_gap_cnt >= i_null_gap) begin
            w_gap_next   = '0;
            w_null_go    = 1'b1;
            w_state_next = S_HEADER;
          end else begin
            w_gap_next = r_gap_cnt + 1'b1;
          end
        end else begin
          w_gap_next = '0;
        end
      end
      S_HEADER: begin
        w_ena_next = 1'b1;
        case (r_idx[1:0])
          2'd0: begin
            w_data_next  = 8'h47;
            w_psync_next = 1'b1;
          end
          2'd1: w_data_next = r_null ? {3'b000, NULL_PID[12:8]} : {1'b0, r_pusi, 1'b0, w_pid[12:8]};
          2'd2: w_data_next = r_null ? NULL_PID[7:0] : w_pid[7:0];
          default: w_data_next = r_null ? 8'h10 : w_ctrl;
        endcase
        if (r_idx[1:0] == 2'd3) begin
          if (r_null)              w_state_next = S_NULL_BODY;
          else if (r_f != 8'd0)    w_state_next = S_AF_LEN;
          else                     w_state_next = w_after_af;
        end else begin
          w_idx_next = r_idx + 8'd1;
        end
      end
      S_AF_LEN: begin
        w_ena_next   = 1'b1;
        w_data_next  = r_f - 8'd1;
        w_state_next = (r_f >= 8'd2) ? S_AF_FLAGS : w_after_af;
      end
      S_AF_FLAGS: begin
        w_ena_next   = 1'b1;
        w_data_next  = 8'h00;
        w_state_next = (r_f >= 8'd3) ? S_AF_STUFF : w_after_af;
      end
      S_AF_STUFF: begin
        w_ena_next  = 1'b1;
        w_data_next = 8'hFF;
        if (r_idx == r_f - 8'd3) w_state_next = w_after_af;
        else                     w_idx_next   = r_idx + 8'd1;
      end
      S_PTR: begin
        w_ena_next   = 1'b1;
        w_data_next  = r_ptr_bad ? 8'hFF : r_ptr;
        w_state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // r_rd_req stays high exactly while fewer than P bytes have been taken.
        if (r_rd_req) begin
          if (i_ena_in) begin
            w_ena_next  = 1'b1;
            w_data_next = i_data_in;
            w_idx_next  = r_idx + 8'd1;
            if (r_idx + 8'd1 == r_p) w_rd_req_next = 1'b0;
          end
        end else begin
          w_cc_inc     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_NULL_BODY: begin
        if (r_idx == 8'd184) begin
          w_state_next = S_IDLE;
        end else begin
          w_ena_next  = 1'b1;
          w_data_next = 8'hFF;
          w_idx_next  = r_idx + 8'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_state_next != r_state) w_idx_next = '0;
    if (w_state_next == S_PAYLOAD && r_state != S_PAYLOAD) w_rd_req_next = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_p       <= '0;
      r_f       <= '0;
      r_pusi    <= 1'b0;
      r_ptr_bad <= 1'b0;
      r_null    <= 1'b0;
      r_gap_cnt <= '0;
      r_data    <= '0;
      r_ena     <= 1'b0;
      r_psync   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_req  <= 1'b0;
      for (int i = 0; i < NUM_STREAMS; i++) r_cc[i] <= '0;
    end else begin
      r_idx     <= w_idx_next;
      r_gap_cnt <= w_gap_next;
      r_data    <= w_data_next;
      r_ena     <= w_ena_next;
      r_psync   <= w_psync_next;
      r_err     <= w_err_next;
      r_rd_req  <= w_rd_req_next;
      if (w_accept) begin
        r_sel     <= w_sel;
        r_ptr     <= i_pointer;
        r_p       <= w_p;
        r_f       <= w_f;
        r_pusi    <= w_pusi;
        r_ptr_bad <= w_ptr_bad;
        r_null    <= 1'b0;
      end else if (w_null_go) begin
        r_null <= 1'b1;
      end
      if (w_cc_inc) r_cc[r_sel] <= r_cc[r_sel] + 4'd1;
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_rd_req    = r_rd_req;
  assign o_data_out  = r_data;
  assign o_ena_out   = r_ena;
  assign o_psync_out = r_psync;
  assign o_err       = r_err;
  assign o_state_mon = r_state;

endmodule
